// File: rtl/rocc_mem_pkg.sv
// Shared definitions for the RoCC memory responder.
// Contents:
//   RESP_ADDR_W / RESP_TAG_W : widths of the fields carried in a response beat
//   M_XRD / M_XWR            : supported memory command codes
//   mem_size_e               : access size encoding (byte/half/word/double)
//   resp_beat_t              : one response beat as held in the latency pipeline
//   byteToBitMask            : expands an 8-lane byte mask to a 64-bit bit mask
package rocc_mem_pkg;

  localparam int RESP_ADDR_W = 40;
  localparam int RESP_TAG_W  = 8;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_e;

  // 'signed' is a keyword, so the signedness echo is called is_signed.
  typedef struct packed {
    logic [RESP_ADDR_W-1:0] addr;
    logic [RESP_TAG_W-1:0]  tag;
    logic [4:0]             cmd;
    mem_size_e              size;
    logic                   is_signed;
    logic [63:0]            data;
    logic [63:0]            data_raw;
    logic [63:0]            store_data;
    logic                   has_data;
  } resp_beat_t;

  function automatic logic [63:0] byteToBitMask(input logic [7:0] byteMask);
    logic [63:0] bitMask;
    bitMask = '0;
    for (int b = 0; b < 8; b++) begin
      bitMask[8*b +: 8] = {8{byteMask[b]}};
    end
    return bitMask;
  endfunction

endpackage

// File: rtl/rocc_mem_responder_if.sv
// RoCC mem_req / mem_resp channel bundle.
// Signals:
//   mem_req_ready              responder -> requester, request may be accepted
//   mem_req_valid, mem_req_bits_*   requester -> responder, the request
//   mem_resp_valid, mem_resp_bits_* responder -> requester, response beat (no ready)
// Modports:
//   slave  : the memory responder side
//   master : the accelerator / bench side
interface rocc_mem_responder_if #(
  parameter int ADDR_W = 40,
  parameter int TAG_W  = 8
);

  logic              mem_req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_bits_addr;
  logic [TAG_W-1:0]  mem_req_bits_tag;
  logic [4:0]        mem_req_bits_cmd;
  logic [1:0]        mem_req_bits_size;
  logic              mem_req_bits_signed;
  logic [63:0]       mem_req_bits_data;

  logic              mem_resp_valid;
  logic [ADDR_W-1:0] mem_resp_bits_addr;
  logic [TAG_W-1:0]  mem_resp_bits_tag;
  logic [4:0]        mem_resp_bits_cmd;
  logic [1:0]        mem_resp_bits_size;
  logic              mem_resp_bits_signed;
  logic [63:0]       mem_resp_bits_data;
  logic [63:0]       mem_resp_bits_data_raw;
  logic [63:0]       mem_resp_bits_store_data;
  logic              mem_resp_bits_has_data;
  logic              mem_resp_bits_replay;

  modport slave (
    output mem_req_ready,
    input  mem_req_valid, mem_req_bits_addr, mem_req_bits_tag, mem_req_bits_cmd,
           mem_req_bits_size, mem_req_bits_signed, mem_req_bits_data,
    output mem_resp_valid, mem_resp_bits_addr, mem_resp_bits_tag, mem_resp_bits_cmd,
           mem_resp_bits_size, mem_resp_bits_signed, mem_resp_bits_data,
           mem_resp_bits_data_raw, mem_resp_bits_store_data, mem_resp_bits_has_data,
           mem_resp_bits_replay
  );

  modport master (
    input  mem_req_ready,
    output mem_req_valid, mem_req_bits_addr, mem_req_bits_tag, mem_req_bits_cmd,
           mem_req_bits_size, mem_req_bits_signed, mem_req_bits_data,
    input  mem_resp_valid, mem_resp_bits_addr, mem_resp_bits_tag, mem_resp_bits_cmd,
           mem_resp_bits_size, mem_resp_bits_signed, mem_resp_bits_data,
           mem_resp_bits_data_raw, mem_resp_bits_store_data, mem_resp_bits_has_data,
           mem_resp_bits_replay
  );

endinterface

// File: rtl/rocc_mem_lanes.sv
// Byte-lane logic for one 64-bit SRAM word access (purely combinational).
// Ports:
//   i_size       access size
//   i_addrLow    addr[2:0]; forced to natural alignment for the size
//   i_signed     sign-extend the load result
//   i_storeData  LSB-aligned store data
//   i_word       current SRAM word at the addressed index
//   o_mergedWord i_word with the selected lanes replaced by the shifted store data
//   o_loadData   selected lanes shifted down and extended to 64 bits
module rocc_mem_lanes
  import rocc_mem_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [2:0]  i_addrLow,
  input  logic        i_signed,
  input  logic [63:0] i_storeData,
  input  logic [63:0] i_word,
  output logic [63:0] o_mergedWord,
  output logic [63:0] o_loadData
);

  logic [2:0]  w_off;
  logic [7:0]  w_byteMask;
  logic [5:0]  w_shamt;
  logic [63:0] w_bitMask;
  logic [63:0] w_storeAligned;
  logic [63:0] w_shifted;

  // Offset low bits below the access size are dropped, so a misaligned
  // request lands on the naturally aligned lanes that contain it.
  always_comb begin
    w_off      = 3'd0;
    w_byteMask = 8'hFF;
    case (i_size)
      SZ_BYTE: begin
        w_off      = i_addrLow;
        w_byteMask = 8'h01 << w_off;
      end
      SZ_HALF: begin
        w_off      = {i_addrLow[2:1], 1'b0};
        w_byteMask = 8'h03 << w_off;
      end
      SZ_WORD: begin
        w_off      = {i_addrLow[2], 2'b00};
        w_byteMask = 8'h0F << w_off;
      end
      default: begin
        w_off      = 3'd0;
        w_byteMask = 8'hFF;
      end
    endcase
  end

  assign w_shamt        = {w_off, 3'b000};
  assign w_bitMask      = byteToBitMask(w_byteMask);
  assign w_storeAligned = i_storeData << w_shamt;
  assign o_mergedWord   = (i_word & ~w_bitMask) | (w_storeAligned & w_bitMask);
  assign w_shifted      = i_word >> w_shamt;

  // Doubles fill the whole result, so signedness has nothing to extend.
  always_comb begin
    o_loadData = w_shifted;
    case (i_size)
      SZ_BYTE: o_loadData = {{56{i_signed & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_loadData = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_loadData = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: o_loadData = w_shifted;
    endcase
  end

endmodule

// File: rtl/rocc_mem_responder.sv
// Synthesizable RoCC memory responder: a 64-bit-word SRAM behind the
// accelerator's mem_req channel, answering with mem_resp beats after a
// fixed LATENCY.
// Ports:
//   clock  single clock
//   reset  asynchronous, active-low
//   stall  back-pressure; holds mem_req_ready low while high
//   busy   at least one response in flight
//   bus    rocc_mem_responder_if slave side (mem_req / mem_resp)
// ADDR_W / TAG_W must match the package response widths (40 / 8).
module rocc_mem_responder
  import rocc_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = RESP_ADDR_W,
  parameter int TAG_W   = RESP_TAG_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  output logic                busy,
  rocc_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [LATENCY-1:0] r_valid;
  resp_beat_t       r_beat [LATENCY];

  logic             w_ready;
  logic             w_fire;
  logic             w_isLoad;
  logic             w_isStore;
  logic [AW-1:0]    w_idx;
  logic [63:0]      w_word;
  logic [63:0]      w_mergedWord;
  logic [63:0]      w_loadData;
  resp_beat_t       w_beat;

  assign w_ready           = reset & ~stall;
  assign bus.mem_req_ready = w_ready;
  assign w_fire            = bus.mem_req_valid & w_ready;
  assign w_isLoad          = (bus.mem_req_bits_cmd == M_XRD);
  assign w_isStore         = (bus.mem_req_bits_cmd == M_XWR);

  // Address bits above the index are ignored so accesses wrap modulo DEPTH.
  assign w_idx  = bus.mem_req_bits_addr[3 +: AW];
  assign w_word = r_mem[w_idx];

  rocc_mem_lanes u_lanes (
    .i_size       (mem_size_e'(bus.mem_req_bits_size)),
    .i_addrLow    (bus.mem_req_bits_addr[2:0]),
    .i_signed     (bus.mem_req_bits_signed),
    .i_storeData  (bus.mem_req_bits_data),
    .i_word       (w_word),
    .o_mergedWord (w_mergedWord),
    .o_loadData   (w_loadData)
  );

  // Everything the response needs is captured in the fire cycle, so later
  // stores or stall changes cannot disturb a beat already in the pipeline.
  // Unsupported commands touch nothing and report zero data.
  always_comb begin
    w_beat            = '0;
    w_beat.addr       = bus.mem_req_bits_addr;
    w_beat.tag        = bus.mem_req_bits_tag;
    w_beat.cmd        = bus.mem_req_bits_cmd;
    w_beat.size       = mem_size_e'(bus.mem_req_bits_size);
    w_beat.is_signed  = bus.mem_req_bits_signed;
    w_beat.store_data = bus.mem_req_bits_data;
    w_beat.has_data   = w_isLoad;
    if (w_isLoad) begin
      w_beat.data     = w_loadData;
      w_beat.data_raw = w_word;
    end else if (w_isStore) begin
      w_beat.data_raw = w_mergedWord;
    end
  end

  // SRAM write port. The read is asynchronous, so a load in the cycle after
  // a store already sees the committed word. Contents survive reset.
  always_ff @(posedge clock) begin
    if (w_fire && w_isStore) begin
      r_mem[w_idx] <= w_mergedWord;
    end
  end

  // LATENCY-deep shift register, one slot per accepted request. Idle slots
  // carry an all-zero beat so the outputs read 0 between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_beat[i] <= '0;
      end
    end else begin
      r_valid[0] <= w_fire;
      r_beat[0]  <= w_fire ? w_beat : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_beat[i]  <= r_beat[i-1];
      end
    end
  end

  assign busy                         = |r_valid;
  assign bus.mem_resp_valid           = r_valid[LATENCY-1];
  assign bus.mem_resp_bits_addr       = r_beat[LATENCY-1].addr[ADDR_W-1:0];
  assign bus.mem_resp_bits_tag        = r_beat[LATENCY-1].tag[TAG_W-1:0];
  assign bus.mem_resp_bits_cmd        = r_beat[LATENCY-1].cmd;
  assign bus.mem_resp_bits_size       = r_beat[LATENCY-1].size;
  assign bus.mem_resp_bits_signed     = r_beat[LATENCY-1].is_signed;
  assign bus.mem_resp_bits_data       = r_beat[LATENCY-1].data;
  assign bus.mem_resp_bits_data_raw   = r_beat[LATENCY-1].data_raw;
  assign bus.mem_resp_bits_store_data = r_beat[LATENCY-1].store_data;
  assign bus.mem_resp_bits_has_data   = r_beat[LATENCY-1].has_data;
  assign bus.mem_resp_bits_replay     = 1'b0;

endmodule

// File: tb/tb_rocc_mem_responder.sv
// Self-checking bench for rocc_mem_responder: a byte-level memory model
// predicts every response beat; directed sequences pin literal values.
module tb_rocc_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int ADDR_W  = 40;
  localparam int TAG_W   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rocc_mem_responder_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  rocc_mem_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .busy(busy), .bus(bus)
  );

  always #5 clock = ~clock;

  // Expected response, as the model derives it from a fired request.
  typedef struct {
    int               due;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0] tag;
    logic [4:0]       cmd;
    logic [1:0]       size;
    logic             sgn;
    logic [63:0]      data;
    logic [63:0]      raw;
    logic [63:0]      sdata;
    logic             hasData;
    bit               known;
  } exp_t;

  exp_t        expQ [$];
  logic [63:0] mdlMem [DEPTH];
  bit          mdlKnown [DEPTH];
  exp_t        mdlEntry;
  exp_t        cmpEntry;
  int          mdlIdx, mdlNb, mdlOff;
  logic [63:0] mdlWord;

  bit logOn = 1'b0;
  int fireLog [$];
  int respCyc [$];
  int respTag [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: on every accepted request, compute the result lane by lane from
  // the byte address arithmetic and queue it for LATENCY cycles later.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset && !stall && bus.mem_req_valid) begin
      mdlEntry.due     = cyc + LATENCY - 1;
      mdlEntry.addr    = bus.mem_req_bits_addr;
      mdlEntry.tag     = bus.mem_req_bits_tag;
      mdlEntry.cmd     = bus.mem_req_bits_cmd;
      mdlEntry.size    = bus.mem_req_bits_size;
      mdlEntry.sgn     = bus.mem_req_bits_signed;
      mdlEntry.sdata   = bus.mem_req_bits_data;
      mdlEntry.data    = '0;
      mdlEntry.raw     = '0;
      mdlEntry.hasData = 1'b0;
      mdlEntry.known   = 1'b1;
      mdlIdx = int'((bus.mem_req_bits_addr / 8) % DEPTH);
      mdlNb  = 1 << int'(bus.mem_req_bits_size);
      mdlOff = (int'(bus.mem_req_bits_addr % 8) / mdlNb) * mdlNb;
      if (bus.mem_req_bits_cmd == 5'd0) begin
        mdlWord = mdlMem[mdlIdx];
        for (int b = 0; b < mdlNb; b++) mdlEntry.data[8*b +: 8] = mdlWord[8*(mdlOff+b) +: 8];
        if (bus.mem_req_bits_signed && mdlNb < 8 && mdlEntry.data[8*mdlNb-1])
          for (int b = mdlNb; b < 8; b++) mdlEntry.data[8*b +: 8] = 8'hFF;
        mdlEntry.raw     = mdlWord;
        mdlEntry.hasData = 1'b1;
        mdlEntry.known   = mdlKnown[mdlIdx];
      end else if (bus.mem_req_bits_cmd == 5'd1) begin
        for (int b = 0; b < mdlNb; b++)
          mdlMem[mdlIdx][8*(mdlOff+b) +: 8] = bus.mem_req_bits_data[8*b +: 8];
        if (mdlNb == 8) mdlKnown[mdlIdx] = 1'b1;
        mdlEntry.raw   = mdlMem[mdlIdx];
        mdlEntry.known = mdlKnown[mdlIdx];
      end
      expQ.push_back(mdlEntry);
    end
  end

  // Reset drops everything in flight.
  always @(negedge reset) expQ.delete();

  // Compare process: every cycle, outputs against the model.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("reset_resp_valid", bus.mem_resp_valid, 64'd0);
      checkOutput("reset_busy", busy, 64'd0);
      checkOutput("reset_ready", bus.mem_req_ready, 64'd0);
      checkOutput("reset_resp_data", bus.mem_resp_bits_data, 64'd0);
    end else begin
      checkOutput("ready", bus.mem_req_ready, 64'(!stall));
      checkOutput("busy", busy, 64'(expQ.size() != 0));
      if (expQ.size() != 0 && expQ[0].due == cyc) begin
        cmpEntry = expQ.pop_front();
        checkOutput("resp_valid", bus.mem_resp_valid, 64'd1);
        checkOutput("resp_addr", bus.mem_resp_bits_addr, cmpEntry.addr);
        checkOutput("resp_tag", bus.mem_resp_bits_tag, cmpEntry.tag);
        checkOutput("resp_cmd", bus.mem_resp_bits_cmd, cmpEntry.cmd);
        checkOutput("resp_size", bus.mem_resp_bits_size, cmpEntry.size);
        checkOutput("resp_signed", bus.mem_resp_bits_signed, cmpEntry.sgn);
        checkOutput("resp_store_data", bus.mem_resp_bits_store_data, cmpEntry.sdata);
        checkOutput("resp_has_data", bus.mem_resp_bits_has_data, cmpEntry.hasData);
        checkOutput("resp_replay", bus.mem_resp_bits_replay, 64'd0);
        if (cmpEntry.known) begin
          checkOutput("resp_data", bus.mem_resp_bits_data, cmpEntry.data);
          checkOutput("resp_data_raw", bus.mem_resp_bits_data_raw, cmpEntry.raw);
        end
      end else begin
        checkOutput("resp_valid", bus.mem_resp_valid, 64'd0);
      end
    end
    if (logOn) begin
      if (reset && !stall && bus.mem_req_valid) fireLog.push_back(cyc);
      if (bus.mem_resp_valid) begin
        respCyc.push_back(cyc);
        respTag.push_back(int'(bus.mem_resp_bits_tag));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] cmd, input logic [1:0] size,
                               input logic sgn, input logic [ADDR_W-1:0] addr,
                               input logic [TAG_W-1:0] tag, input logic [63:0] data);
    @(posedge clock);
    #1;
    bus.mem_req_valid       = v;
    bus.mem_req_bits_cmd    = cmd;
    bus.mem_req_bits_size   = size;
    bus.mem_req_bits_signed = sgn;
    bus.mem_req_bits_addr   = addr;
    bus.mem_req_bits_tag    = tag;
    bus.mem_req_bits_data   = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 2'd0, 1'b0, '0, '0, '0);
  endtask

  // Waits (bounded) for the next response beat and pins it to literals.
  task automatic expectResp(input string name, input logic [TAG_W-1:0] tag,
                            input logic [63:0] data, input logic [63:0] raw,
                            input logic hasData);
    bit seen = 1'b0;
    for (int i = 0; i < LATENCY + 4 && !seen; i++) begin
      @(negedge clock);
      if (bus.mem_resp_valid) begin
        seen = 1'b1;
        checkOutput({name, "_tag"}, bus.mem_resp_bits_tag, tag);
        checkOutput({name, "_data"}, bus.mem_resp_bits_data, data);
        checkOutput({name, "_raw"}, bus.mem_resp_bits_data_raw, raw);
        checkOutput({name, "_has_data"}, bus.mem_resp_bits_has_data, hasData);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no response required=response", name);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.mem_req_valid       = 1'b0;
    bus.mem_req_bits_addr   = '0;
    bus.mem_req_bits_tag    = '0;
    bus.mem_req_bits_cmd    = 5'd0;
    bus.mem_req_bits_size   = 2'd0;
    bus.mem_req_bits_signed = 1'b0;
    bus.mem_req_bits_data   = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("init_ready", bus.mem_req_ready, 64'd0);
    checkOutput("init_busy", busy, 64'd0);
    checkOutput("init_tag", bus.mem_resp_bits_tag, 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    idle(1);

    $display("[TB] store then load, double");
    applyStimulus(1'b1, 5'd1, 2'd3, 1'b0, 40'h40, 8'd1, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h40, 8'd5, 64'd0);
    idle(1);
    expectResp("dbl_store", 8'd1, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    expectResp("dbl_load", 8'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);

    $display("[TB] byte store, signed and unsigned loads");
    applyStimulus(1'b1, 5'd1, 2'd3, 1'b0, 40'h0, 8'd2, 64'd0);
    idle(1);
    expectResp("clr0", 8'd2, 64'd0, 64'd0, 1'b0);
    applyStimulus(1'b1, 5'd1, 2'd0, 1'b0, 40'h3, 8'd3, 64'hFF);
    idle(1);
    expectResp("byte_store", 8'd3, 64'd0, 64'h0000_0000_FF00_0000, 1'b0);
    applyStimulus(1'b1, 5'd0, 2'd0, 1'b1, 40'h3, 8'd4, 64'd0);
    idle(1);
    expectResp("byte_ld_s", 8'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FF00_0000, 1'b1);
    applyStimulus(1'b1, 5'd0, 2'd0, 1'b0, 40'h3, 8'd6, 64'd0);
    idle(1);
    expectResp("byte_ld_u", 8'd6, 64'h0000_0000_0000_00FF, 64'h0000_0000_FF00_0000, 1'b1);
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h0, 8'd7, 64'd0);
    idle(1);
    expectResp("byte_ld_d", 8'd7, 64'h0000_0000_FF00_0000, 64'h0000_0000_FF00_0000, 1'b1);

    $display("[TB] misaligned half");
    applyStimulus(1'b1, 5'd1, 2'd3, 1'b0, 40'h0, 8'd8, 64'd0);
    idle(1);
    expectResp("clr0b", 8'd8, 64'd0, 64'd0, 1'b0);
    applyStimulus(1'b1, 5'd1, 2'd1, 1'b0, 40'h5, 8'd9, 64'hBEEF);
    idle(1);
    expectResp("half_store", 8'd9, 64'd0, 64'h0000_BEEF_0000_0000, 1'b0);
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h0, 8'd10, 64'd0);
    idle(1);
    expectResp("half_ld_d", 8'd10, 64'h0000_BEEF_0000_0000, 64'h0000_BEEF_0000_0000, 1'b1);
    applyStimulus(1'b1, 5'd0, 2'd1, 1'b1, 40'h5, 8'd11, 64'd0);
    idle(1);
    expectResp("half_ld_s", 8'd11, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0000_BEEF_0000_0000, 1'b1);
    applyStimulus(1'b1, 5'd0, 2'd2, 1'b1, 40'h6, 8'd12, 64'd0);
    idle(1);
    expectResp("word_ld_s", 8'd12, 64'h0000_0000_0000_BEEF, 64'h0000_BEEF_0000_0000, 1'b1);

    $display("[TB] unsupported cmd");
    applyStimulus(1'b1, 5'd2, 2'd3, 1'b0, 40'h40, 8'd13, 64'h55);
    idle(1);
    expectResp("bad_cmd", 8'd13, 64'd0, 64'd0, 1'b0);
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h40, 8'd14, 64'd0);
    idle(1);
    expectResp("after_bad", 8'd14, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);

    $display("[TB] streaming");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 5'd1, 2'd3, 1'b0, 40'(i * 8), 8'(32 + i),
                    {32'hA5A5_0000 | 32'(i), 32'(i * 7)});
    idle(LATENCY + 2);
    logOn = 1'b1;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'(i * 8), 8'(i), 64'd0);
    idle(LATENCY + 4);
    logOn = 1'b0;
    checkOutput("stream_fires", 64'(fireLog.size()), 64'd16);
    checkOutput("stream_resps", 64'(respCyc.size()), 64'd16);
    if (fireLog.size() == 16 && respCyc.size() == 16) begin
      checkOutput("stream_latency", 64'(respCyc[0] - fireLog[0]), 64'(LATENCY));
      for (int i = 0; i < 16; i++) begin
        checkOutput("stream_tag", 64'(respTag[i]), 64'(i));
        checkOutput("stream_gapless", 64'(respCyc[i] - respCyc[0]), 64'(i));
      end
    end

    $display("[TB] stall and wrap-around");
    @(posedge clock);
    #1;
    stall = 1'b1;
    bus.mem_req_valid     = 1'b1;
    bus.mem_req_bits_cmd  = 5'd0;
    bus.mem_req_bits_size = 2'd3;
    bus.mem_req_bits_addr = 40'h0;
    bus.mem_req_bits_tag  = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_ready", bus.mem_req_ready, 64'd0);
      checkOutput("stall_no_resp", bus.mem_resp_valid, 64'd0);
    end
    @(posedge clock);
    #1 stall = 1'b0;
    bus.mem_req_valid       = 1'b1;
    bus.mem_req_bits_cmd    = 5'd1;
    bus.mem_req_bits_size   = 2'd3;
    bus.mem_req_bits_signed = 1'b0;
    bus.mem_req_bits_addr   = 40'(DEPTH * 8);
    bus.mem_req_bits_tag    = 8'h31;
    bus.mem_req_bits_data   = 64'hCAFE_F00D_DEAD_BEEF;
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h0, 8'h32, 64'd0);
    idle(1);
    expectResp("wrap_store", 8'h31, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
    expectResp("wrap_load", 8'h32, 64'hCAFE_F00D_DEAD_BEEF, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h40, 8'h40, 64'd0);
    @(posedge clock);
    #1;
    bus.mem_req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rst_busy_now", busy, 64'd0);
    checkOutput("rst_valid_now", bus.mem_resp_valid, 64'd0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    idle(1);
    applyStimulus(1'b1, 5'd0, 2'd3, 1'b0, 40'h0, 8'h41, 64'd0);
    idle(1);
    expectResp("post_rst", 8'h41, 64'hCAFE_F00D_DEAD_BEEF, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);

    idle(LATENCY + 3);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
